engine_dispatcher: RTL and testbench

- Scheduler between the raster pixel source and the NUM_ENGINES mandelbrot engines.
- Walks the frame in raster order (x fastest) and issues each pixel coordinate to the lowest-index engine that is idle and whose output queue is not full.
- Tracks per-engine busy state from start/done handshakes.
- Signals frame completion once every pixel has been dispatched and every engine has drained.

---
 rtl/mandel_pkg.sv | 17 +
 rtl/engine_dispatcher_prio_pick.sv | 23 ++
 rtl/engine_dispatcher.sv | 118 +++++++++++
 tb/tb_engine_dispatcher.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared types and default frame geometry for the mandelbrot datapath.
package mandel_pkg;

  localparam int DEFAULT_NUM_ENGINES = 3;
  localparam int DEFAULT_PIXEL_WIDTH = 32;
  localparam int DEFAULT_FRAME_W     = 640;
  localparam int DEFAULT_FRAME_H     = 480;

  typedef logic [DEFAULT_PIXEL_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } disp_state_t;

endpackage

// File: rtl/engine_dispatcher_prio_pick.sv
// Lowest-index one-hot picker over a vector of request bits.
module prio_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         any
);

  // Scan from the top down so the lowest set request is the last one written
  always_comb begin
    grant = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/engine_dispatcher.sv
// Raster-order pixel scheduler feeding a bank of mandelbrot engines.
// Each pixel goes to the lowest-index engine that is idle and whose
// output queue has room; frame_done fires once every engine has drained.
module engine_dispatcher
  import mandel_pkg::*;
#(
  parameter int NUM_ENGINES = DEFAULT_NUM_ENGINES,
  parameter int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
  parameter int FRAME_W     = DEFAULT_FRAME_W,
  parameter int FRAME_H     = DEFAULT_FRAME_H
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [NUM_ENGINES-1:0] eng_done,
  input  logic [NUM_ENGINES-1:0] queue_full,
  output logic [NUM_ENGINES-1:0] eng_start,
  output logic [PIXEL_WIDTH-1:0] px_x,
  output logic [PIXEL_WIDTH-1:0] px_y,
  output logic [NUM_ENGINES-1:0] eng_busy,
  output logic                   busy,
  output logic                   frame_done
);

  localparam logic [PIXEL_WIDTH-1:0] X_LAST = PIXEL_WIDTH'(FRAME_W - 1);
  localparam logic [PIXEL_WIDTH-1:0] Y_LAST = PIXEL_WIDTH'(FRAME_H - 1);
  localparam logic [PIXEL_WIDTH-1:0] ONE    = PIXEL_WIDTH'(1);

  disp_state_t            state;
  logic [PIXEL_WIDTH-1:0] x_cnt;
  logic [PIXEL_WIDTH-1:0] y_cnt;
  logic [NUM_ENGINES-1:0] eligible;
  logic [NUM_ENGINES-1:0] pick;
  logic                   pick_any;
  logic                   dispatch;
  logic [NUM_ENGINES-1:0] busy_next;
  logic                   x_last;
  logic                   y_last;

  // Eligibility looks only at the registered busy flags, so an engine whose
  // done arrives this cycle is not restarted until the following cycle.
  assign eligible = ~eng_busy & ~queue_full;

  prio_pick #(
    .N(NUM_ENGINES)
  ) u_pick (
    .req  (eligible),
    .grant(pick),
    .any  (pick_any)
  );

  assign dispatch = (state == RUN) && pick_any;
  assign x_last   = (x_cnt == X_LAST);
  assign y_last   = (y_cnt == Y_LAST);
  assign busy     = (state != IDLE);

  // Done pulses clear their engine, a dispatch marks the picked engine busy
  always_comb begin
    busy_next = eng_busy & ~eng_done;
    if (dispatch) begin
      busy_next = busy_next | pick;
    end
  end

  // Frame walker: issues pixels in raster order and waits for the engines to drain
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x_cnt      <= '0;
      y_cnt      <= '0;
      eng_start  <= '0;
      px_x       <= '0;
      px_y       <= '0;
      eng_busy   <= '0;
      frame_done <= 1'b0;
    end else begin
      eng_start  <= '0;
      frame_done <= 1'b0;
      eng_busy   <= busy_next;
      case (state)
        IDLE: begin
          if (frame_start) begin
            state <= RUN;
            x_cnt <= '0;
            y_cnt <= '0;
          end
        end
        RUN: begin
          if (pick_any) begin
            eng_start <= pick;
            px_x      <= x_cnt;
            px_y      <= y_cnt;
            if (x_last) begin
              x_cnt <= '0;
              if (y_last) begin
                state <= DRAIN;
              end else begin
                y_cnt <= y_cnt + ONE;
              end
            end else begin
              x_cnt <= x_cnt + ONE;
            end
          end
        end
        DRAIN: begin
          if (eng_busy == '0) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_engine_dispatcher.sv
// Scoreboard bench for engine_dispatcher on a 4x2 frame with three engines.
module tb_engine_dispatcher;
  import mandel_pkg::*;

  localparam int NE = 3;
  localparam int FW = 4;
  localparam int FH = 2;
  localparam int PW = 32;

  typedef struct {
    logic [NE-1:0] eng;
    pixel_t        x;
    pixel_t        y;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic [NE-1:0] queue_full = '0;
  logic [NE-1:0] auto_done = '0;
  logic [NE-1:0] manual_done = '0;
  logic [NE-1:0] eng_done;
  logic [NE-1:0] eng_start;
  logic [PW-1:0] px_x;
  logic [PW-1:0] px_y;
  logic [NE-1:0] eng_busy;
  logic          busy;
  logic          frame_done;

  exp_t   exp_q[$];
  int     disp_cycles[$];
  int     checks = 0;
  int     fails = 0;
  int     cyc = 0;
  int     last_done_edge = -10;
  int     frame_done_cnt = 0;
  int     done_delay = 0;
  int     resp_cnt[NE];
  pixel_t model_x = '0;
  pixel_t model_y = '0;

  // Engine ordering when every engine answers 5 cycles after its start
  logic [NE-1:0] rr_engs   [8] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
  // Engine 0 blocked by its queue: engines 1 and 2 alternate
  logic [NE-1:0] q0_engs   [8] = '{3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010, 3'b100};
  // Hand-driven done pattern: 010 alone, then 111, then 001
  logic [NE-1:0] hand_engs [8] = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b001, 3'b010, 3'b100, 3'b001};

  assign eng_done = auto_done | manual_done;

  engine_dispatcher #(
    .NUM_ENGINES(NE),
    .PIXEL_WIDTH(PW),
    .FRAME_W    (FW),
    .FRAME_H    (FH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .eng_done   (eng_done),
    .queue_full (queue_full),
    .eng_start  (eng_start),
    .px_x       (px_x),
    .px_y       (px_y),
    .eng_busy   (eng_busy),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic fs, input logic [NE-1:0] done_mask);
    @(negedge clk);
    frame_start = fs;
    manual_done = done_mask;
    @(negedge clk);
    frame_start = 1'b0;
    manual_done = '0;
  endtask

  task automatic pushFrame(input logic [NE-1:0] engs [8], input int count);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      e.eng = engs[i];
      e.x   = pixel_t'(i % FW);
      e.y   = pixel_t'(i / FW);
      exp_q.push_back(e);
    end
  endtask

  task automatic waitQueueLevel(input int level, input int budget);
    int n = 0;
    while (exp_q.size() > level && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("dispatch_count", exp_q.size(), level);
  endtask

  task automatic waitFrameDone(input int budget);
    int start_cnt = frame_done_cnt;
    int n = 0;
    while (frame_done_cnt == start_cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("frame_done_pulses", frame_done_cnt - start_cnt, 1);
  endtask

  // Engine model: raises done for one cycle done_delay cycles after each start
  always @(negedge clk) begin
    for (int i = 0; i < NE; i++) begin
      auto_done[i] = 1'b0;
      if (reset) begin
        resp_cnt[i] = 0;
      end else begin
        if (resp_cnt[i] > 0) begin
          resp_cnt[i] = resp_cnt[i] - 1;
          if (resp_cnt[i] == 0) auto_done[i] = 1'b1;
        end
        if (eng_start[i] && done_delay > 0) resp_cnt[i] = done_delay;
      end
    end
  end

  // Monitor: pops the scoreboard on every start pulse and checks frame_done timing
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (eng_done != '0) last_done_edge = cyc;
    if (reset) begin
      model_x = '0;
      model_y = '0;
    end else begin
      if (eng_start != '0) begin
        disp_cycles.push_back(cyc);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_start", 32'(eng_start), 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("start_engine", 32'(eng_start), 32'(e.eng));
          checkOutput("start_px_x", px_x, e.x);
          checkOutput("start_px_y", px_y, e.y);
          model_x = e.x;
          model_y = e.y;
        end
      end else begin
        checkOutput("hold_px_x", px_x, model_x);
        checkOutput("hold_px_y", px_y, model_y);
      end
      if (frame_done) begin
        frame_done_cnt++;
        checkOutput("frame_done_latency", cyc, last_done_edge + 1);
      end
    end
  end

  // Safety net so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int d;
    int n;
    int saved;

    repeat (3) @(negedge clk);
    checkOutput("reset_eng_start", 32'(eng_start), 32'd0);
    checkOutput("reset_px_x", px_x, 32'd0);
    checkOutput("reset_px_y", px_y, 32'd0);
    checkOutput("reset_eng_busy", 32'(eng_busy), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b0;

    $display("[TB] test 1: full frame, engines answer after 5 cycles");
    done_delay = 5;
    pushFrame(rr_engs, 8);
    applyStimulus(1'b1, '0);
    waitQueueLevel(0, 100);
    waitFrameDone(100);
    checkOutput("t1_busy_after", 32'(busy), 32'd0);
    checkOutput("t1_eng_busy_after", 32'(eng_busy), 32'd0);

    $display("[TB] test 2: engine 0 queue full for the whole frame");
    queue_full = 3'b001;
    pushFrame(q0_engs, 8);
    applyStimulus(1'b1, '0);
    waitQueueLevel(0, 100);
    waitFrameDone(100);
    queue_full = '0;
    checkOutput("t2_busy_after", 32'(busy), 32'd0);

    $display("[TB] test 3: single done while all engines busy");
    done_delay = 0;
    pushFrame(hand_engs, 8);
    applyStimulus(1'b1, '0);
    waitQueueLevel(5, 20);
    repeat (2) @(negedge clk);
    checkOutput("t3_all_busy", 32'(eng_busy), 32'b111);
    checkOutput("t3_run_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 3'b010);
    d = last_done_edge;
    waitQueueLevel(4, 20);
    checkOutput("t3_reuse_latency", disp_cycles[disp_cycles.size() - 1], d + 1);

    $display("[TB] test 4: simultaneous done on all engines");
    applyStimulus(1'b0, 3'b111);
    d = last_done_edge;
    waitQueueLevel(1, 20);
    n = disp_cycles.size();
    checkOutput("t4_first_cycle", disp_cycles[n - 3], d + 1);
    checkOutput("t4_second_cycle", disp_cycles[n - 2], d + 2);
    checkOutput("t4_third_cycle", disp_cycles[n - 1], d + 3);
    applyStimulus(1'b0, 3'b001);
    waitQueueLevel(0, 20);
    @(negedge clk);
    checkOutput("t4_drain_busy", 32'(busy), 32'd1);
    checkOutput("t4_drain_eng_busy", 32'(eng_busy), 32'b111);
    applyStimulus(1'b0, 3'b111);
    waitFrameDone(20);
    checkOutput("t4_eng_busy_after", 32'(eng_busy), 32'd0);

    $display("[TB] test 5: reset in the middle of a frame");
    pushFrame(rr_engs, 3);
    applyStimulus(1'b1, '0);
    waitQueueLevel(0, 20);
    saved = frame_done_cnt;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_eng_start", 32'(eng_start), 32'd0);
    checkOutput("t5_px_x", px_x, 32'd0);
    checkOutput("t5_px_y", px_y, 32'd0);
    checkOutput("t5_eng_busy", 32'(eng_busy), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("t5_no_frame_done", frame_done_cnt, saved);

    $display("[TB] test 6: stray frame_start and done pulses, frame restarts at origin");
    done_delay = 5;
    applyStimulus(1'b0, 3'b010);
    pushFrame(rr_engs, 8);
    applyStimulus(1'b1, '0);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, '0);
    waitQueueLevel(0, 100);
    applyStimulus(1'b1, 3'b100);
    waitFrameDone(100);
    repeat (5) @(negedge clk);
    checkOutput("t6_stays_idle", 32'(busy), 32'd0);
    checkOutput("t6_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
